// File: rtl/tdc_pkg.sv
// Shared types and constants for the TDC hit sequencer.
// States, record layout and drop-counter saturation value.
package tdc_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMED,
    S_WAIT_FALL,
    S_WAIT_LOW,
    S_DEAD
  } state_e;

  localparam int COARSE_W_DEF = 16;
  localparam int FINE_W_DEF   = 6;
  localparam int WIDTH_W_DEF  = 16;
  localparam int TS_W = COARSE_W_DEF + FINE_W_DEF;

  typedef struct packed {
    logic                   ovf;
    logic [TS_W-1:0]        ts;
    logic [WIDTH_W_DEF-1:0] width;
  } tdc_rec_t;

  localparam logic [15:0] DROP_MAX = 16'hFFFF;

endpackage

// File: rtl/tdc_coarse_counter.sv
// Free-running coarse time counter.
// Wraps at 2^W; synchronous active-high reset.
module tdc_coarse_counter #(
  parameter int W = 16
) (
  input  logic         i_clk,
  input  logic         i_rst,
  output logic [W-1:0] o_count
);

  logic [W-1:0] r_count;

  always_ff @(posedge i_clk) begin
    if (i_rst) r_count <= '0;
    else       r_count <= r_count + 1'b1;
  end

  assign o_count = r_count;

endmodule

// File: rtl/tdc_hit_sequencer.sv
// TDC channel sequencer: pairs rise/fall edges into records,
// applies dead time and width timeout, counts dropped records.
module tdc_hit_sequencer
  import tdc_pkg::*;
#(
  parameter int COARSE_W    = 16,
  parameter int FINE_W      = 6,
  parameter int WIDTH_W     = 16,
  parameter int MAX_WIDTH   = 1000,
  parameter int DEAD_CYCLES = 4
) (
  input  logic                         iCLK0,
  input  logic                         iRST,
  input  logic                         iEN,
  input  logic                         iRISE,
  input  logic                         iFALL,
  input  logic [FINE_W-1:0]            iFINE,
  output logic                         oVALID,
  input  logic                         iREADY,
  output logic [COARSE_W+FINE_W-1:0]   oTS,
  output logic [WIDTH_W-1:0]           oWIDTH,
  output logic                         oOVF,
  output logic                         oBUSY,
  output logic [15:0]                  oDROP_CNT
);

  localparam int P_TS_W = COARSE_W + FINE_W;
  localparam int CNT_W  = $clog2(MAX_WIDTH + DEAD_CYCLES + 1);

  logic [COARSE_W-1:0] w_coarse;
  logic [P_TS_W-1:0]   w_ts_now;
  logic [P_TS_W-1:0]   w_diff;
  logic                w_rise;
  logic                w_fall;
  logic                w_tmo;
  logic                w_dead_end;

  state_e              r_state;
  state_e              w_state_nx;
  logic [CNT_W-1:0]    r_cnt;
  logic [CNT_W-1:0]    w_cnt_nx;
  logic [P_TS_W-1:0]   r_ts_r;
  logic                w_cap;
  logic                w_rec;
  logic                w_rec_ovf;
  logic [WIDTH_W-1:0]  w_rec_width;

  logic                r_valid;
  logic [P_TS_W-1:0]   r_ts;
  logic [WIDTH_W-1:0]  r_width;
  logic                r_ovf;
  logic                r_busy;
  logic [15:0]         r_drop;

  tdc_coarse_counter #(
    .W (COARSE_W)
  ) u_coarse (
    .i_clk   (iCLK0),
    .i_rst   (iRST),
    .o_count (w_coarse)
  );

  // Coincident rise and fall cancel each other in every state.
  assign w_rise     = iRISE & ~iFALL;
  assign w_fall     = iFALL & ~iRISE;
  assign w_ts_now   = {w_coarse, iFINE};
  assign w_diff     = w_ts_now - r_ts_r;
  assign w_tmo      = (r_cnt == CNT_W'(MAX_WIDTH - 2));
  assign w_dead_end = (r_cnt == CNT_W'(DEAD_CYCLES - 1));

  always_comb begin
    w_state_nx  = r_state;
    w_cnt_nx    = r_cnt + 1'b1;
    w_cap       = 1'b0;
    w_rec       = 1'b0;
    w_rec_ovf   = 1'b0;
    w_rec_width = w_diff[WIDTH_W-1:0];
    unique case (r_state)
      S_IDLE: begin
        if (iEN) w_state_nx = S_ARMED;
      end
      S_ARMED: begin
        if (!iEN) begin
          w_state_nx = S_IDLE;
        end else if (w_rise) begin
          w_state_nx = S_WAIT_FALL;
          w_cnt_nx   = '0;
          w_cap      = 1'b1;
        end
      end
      S_WAIT_FALL: begin
        if (w_fall) begin
          w_state_nx = S_DEAD;
          w_cnt_nx   = '0;
          w_rec      = 1'b1;
        end else if (w_tmo) begin
          w_state_nx  = S_WAIT_LOW;
          w_rec       = 1'b1;
          w_rec_ovf   = 1'b1;
          w_rec_width = '1;
        end
      end
      S_WAIT_LOW: begin
        if (w_fall) begin
          w_state_nx = S_DEAD;
          w_cnt_nx   = '0;
        end
      end
      S_DEAD: begin
        if (w_dead_end) w_state_nx = iEN ? S_ARMED : S_IDLE;
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge iCLK0) begin
    if (iRST) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_ts_r  <= '0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      if (w_cap) r_ts_r <= w_ts_now;
      r_busy  <= (w_state_nx == S_WAIT_FALL) ||
                 (w_state_nx == S_WAIT_LOW) ||
                 (w_state_nx == S_DEAD);
    end
  end

  // Single-entry output register; a blocked record is dropped.
  always_ff @(posedge iCLK0) begin
    if (iRST) begin
      r_valid <= 1'b0;
      r_ts    <= '0;
      r_width <= '0;
      r_ovf   <= 1'b0;
      r_drop  <= '0;
    end else if (w_rec) begin
      if (!r_valid || iREADY) begin
        r_valid <= 1'b1;
        r_ts    <= r_ts_r;
        r_width <= w_rec_width;
        r_ovf   <= w_rec_ovf;
      end else if (r_drop != DROP_MAX) begin
        r_drop  <= r_drop + 16'd1;
      end
    end else if (iREADY) begin
      r_valid <= 1'b0;
    end
  end

  assign oVALID    = r_valid;
  assign oTS       = r_ts;
  assign oWIDTH    = r_width;
  assign oOVF      = r_ovf;
  assign oBUSY     = r_busy;
  assign oDROP_CNT = r_drop;

endmodule

// File: tb/tb_tdc_hit_sequencer.sv
// Directed bench for tdc_hit_sequencer.
// Expected values are hand-computed from edge cycles and fine codes.
module tb_tdc_hit_sequencer;

  logic        iCLK0 = 1'b0;
  logic        iRST  = 1'b1;
  logic        iEN   = 1'b0;
  logic        iRISE = 1'b0;
  logic        iFALL = 1'b0;
  logic [5:0]  iFINE = '0;
  logic        iREADY = 1'b0;
  logic        oVALID;
  logic [21:0] oTS;
  logic [15:0] oWIDTH;
  logic        oOVF;
  logic        oBUSY;
  logic [15:0] oDROP_CNT;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  tdc_hit_sequencer dut (
    .iCLK0     (iCLK0),
    .iRST      (iRST),
    .iEN       (iEN),
    .iRISE     (iRISE),
    .iFALL     (iFALL),
    .iFINE     (iFINE),
    .oVALID    (oVALID),
    .iREADY    (iREADY),
    .oTS       (oTS),
    .oWIDTH    (oWIDTH),
    .oOVF      (oOVF),
    .oBUSY     (oBUSY),
    .oDROP_CNT (oDROP_CNT)
  );

  always #5 iCLK0 = ~iCLK0;

  task automatic tick;
    @(posedge iCLK0);
    #1;
    cyc = (cyc + 1) % 65536;
  endtask

  task automatic go_to(input int c);
    while (cyc != c) tick();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, 32'(oVALID), 0);
    chk({tag, "_ts"}, 32'(oTS), 0);
    chk({tag, "_width"}, 32'(oWIDTH), 0);
    chk({tag, "_ovf"}, 32'(oOVF), 0);
    chk({tag, "_busy"}, 32'(oBUSY), 0);
    chk({tag, "_drop"}, 32'(oDROP_CNT), 0);
  endtask

  initial begin
    tick();
    tick();
    chk_zero("rst");
    iRST = 1'b0;
    iEN  = 1'b1;
    cyc  = 0;

    // basic hit
    go_to(100);
    iRISE = 1; iFINE = 10; tick(); iRISE = 0;
    chk("basic_busy", 32'(oBUSY), 1);
    go_to(103);
    chk("basic_pre_valid", 32'(oVALID), 0);
    iFALL = 1; iFINE = 5; tick(); iFALL = 0;
    chk("basic_valid", 32'(oVALID), 1);
    chk("basic_ts", 32'(oTS), 6410);
    chk("basic_width", 32'(oWIDTH), 187);
    chk("basic_ovf", 32'(oOVF), 0);
    iREADY = 1; tick(); iREADY = 0;
    chk("basic_consumed", 32'(oVALID), 0);
    chk("basic_dead_busy", 32'(oBUSY), 1);

    // timeout
    go_to(200);
    iRISE = 1; iFINE = 7; tick(); iRISE = 0;
    go_to(1199);
    chk("tmo_early", 32'(oVALID), 0);
    go_to(1200);
    chk("tmo_valid", 32'(oVALID), 1);
    chk("tmo_ovf", 32'(oOVF), 1);
    chk("tmo_width", 32'(oWIDTH), 16'hFFFF);
    chk("tmo_ts", 32'(oTS), 12807);
    iREADY = 1; tick(); iREADY = 0;
    chk("tmo_consumed", 32'(oVALID), 0);
    chk("tmo_waitlow_busy", 32'(oBUSY), 1);
    go_to(1700);
    iFALL = 1; iFINE = 0; tick(); iFALL = 0;
    chk("tmo_fall_norec", 32'(oVALID), 0);
    chk("tmo_fall_dead", 32'(oBUSY), 1);
    go_to(1704);
    iRISE = 1; tick(); iRISE = 0;
    chk("tmo_early_rise", 32'(oBUSY), 0);
    iRISE = 1; tick(); iRISE = 0;
    chk("tmo_rearm_rise", 32'(oBUSY), 1);
    go_to(1708);
    iFALL = 1; tick(); iFALL = 0;
    chk("tmo_next_valid", 32'(oVALID), 1);
    chk("tmo_next_width", 32'(oWIDTH), 192);
    chk("tmo_next_ovf", 32'(oOVF), 0);
    iREADY = 1; tick(); iREADY = 0;

    // back-pressure
    go_to(3000);
    iRISE = 1; iFINE = 1; tick(); iRISE = 0;
    go_to(3002);
    iFALL = 1; iFINE = 1; tick(); iFALL = 0;
    go_to(3010);
    iRISE = 1; iFINE = 0; tick(); iRISE = 0;
    iFALL = 1; iFINE = 2; tick(); iFALL = 0;
    chk("bp_valid", 32'(oVALID), 1);
    chk("bp_ts", 32'(oTS), 192001);
    chk("bp_width", 32'(oWIDTH), 128);
    chk("bp_drop", 32'(oDROP_CNT), 1);
    go_to(3013);
    iREADY = 1; tick(); iREADY = 0;
    chk("bp_release", 32'(oVALID), 0);
    go_to(3020);
    iRISE = 1; iFINE = 0; tick(); iRISE = 0;
    go_to(3022);
    iFALL = 1; tick(); iFALL = 0;
    chk("bp_c_valid", 32'(oVALID), 1);
    go_to(3030);
    iRISE = 1; iFINE = 3; tick(); iRISE = 0;
    iFALL = 1; iFINE = 7; iREADY = 1; tick(); iFALL = 0;
    chk("bp_swap_valid", 32'(oVALID), 1);
    chk("bp_swap_ts", 32'(oTS), 193923);
    chk("bp_swap_width", 32'(oWIDTH), 68);
    chk("bp_swap_drop", 32'(oDROP_CNT), 1);

    // dead time and ignored edges
    go_to(3100);
    iRISE = 1; iFINE = 0; tick(); iRISE = 0;
    go_to(3102);
    iFALL = 1; tick(); iFALL = 0;
    chk("dead_rec_valid", 32'(oVALID), 1);
    chk("dead_rec_ts", 32'(oTS), 198400);
    chk("dead_rec_width", 32'(oWIDTH), 128);
    go_to(3105);
    iRISE = 1; tick(); iRISE = 0;
    chk("dead_busy_f4", 32'(oBUSY), 1);
    tick();
    chk("dead_rise_ignored", 32'(oBUSY), 0);
    go_to(3110);
    iRISE = 1; iFALL = 1; tick(); iRISE = 0; iFALL = 0;
    chk("both_edges_ignored", 32'(oBUSY), 0);
    iFALL = 1; tick(); iFALL = 0;
    chk("armed_fall_busy", 32'(oBUSY), 0);
    chk("armed_fall_norec", 32'(oVALID), 0);

    // coarse wrap
    go_to(65535);
    iRISE = 1; iFINE = 60; tick(); iRISE = 0;
    go_to(1);
    iFALL = 1; iFINE = 4; tick(); iFALL = 0;
    chk("wrap_valid", 32'(oVALID), 1);
    chk("wrap_ts", 32'(oTS), 4194300);
    chk("wrap_width", 32'(oWIDTH), 72);
    chk("wrap_ovf", 32'(oOVF), 0);

    // reset mid-hit
    go_to(100);
    iRISE = 1; iFINE = 0; tick(); iRISE = 0;
    tick();
    iRST = 1; tick();
    chk_zero("rst_mid");
    iRST = 0;
    cyc  = 0;
    iFALL = 1; tick(); iFALL = 0;
    chk("rst_fall_norec", 32'(oVALID), 0);
    chk("rst_fall_busy", 32'(oBUSY), 0);
    iRISE = 1; tick(); iRISE = 0;
    chk("rst_rearm", 32'(oBUSY), 1);
    go_to(5);
    iFALL = 1; tick(); iFALL = 0;
    chk("rst_next_valid", 32'(oVALID), 1);
    chk("rst_next_ts", 32'(oTS), 64);
    chk("rst_next_width", 32'(oWIDTH), 256);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
